// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared states, class indices and helpers for the FIFO arbiter controller
package fifo_ctrl_pkg;

    localparam int NUM_REQ = 4;

    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int D0 = 2;
    localparam int D1 = 3;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot grant over the class requests; ARB_RR_EN selects round-robin, else fixed priority
module rr_arbiter
    import fifo_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

`ifdef ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;
    logic       found;

    // Search starts at the pointer; the pointer moves just past the winner.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr_q + 2'(i);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, reset};

    always_comb begin
        gnt = '0;
        if (en) begin
            if      (req[P0]) gnt[P0] = 1'b1;
            else if (req[P1]) gnt[P1] = 1'b1;
            else if (req[D0]) gnt[D0] = 1'b1;
            else if (req[D1]) gnt[D1] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/fifo_arb_ctrl.sv
// rtl/fifo_arb_ctrl.sv - init sequencing, threshold distribution and class arbitration into the downstream FIFO (ARB_RR_EN: round-robin)
module fifo_arb_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int UMBRAL_W   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_init,
    input  logic [UMBRAL_W-1:0]           cfg_umbral_af,
    input  logic [UMBRAL_W-1:0]           cfg_umbral_ae,
    input  logic [NUM_REQ-1:0]            src_empty,
    input  logic [NUM_REQ-1:0]            src_error,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data,
    input  logic                          dst_full,
    input  logic                          dst_almost_full,
    output logic                          fifo_init,
    output logic [UMBRAL_W-1:0]           umbral_af_o,
    output logic [UMBRAL_W-1:0]           umbral_ae_o,
    output logic [NUM_REQ-1:0]            src_pop,
    output logic                          dst_push,
    output logic [DATA_WIDTH-1:0]         dst_data,
    output logic [1:0]                    state_o,
    output logic                          error_o
);

    state_e                state_q, state_d;
    logic [UMBRAL_W-1:0]   umbral_af_q, umbral_af_d;
    logic [UMBRAL_W-1:0]   umbral_ae_q, umbral_ae_d;
    logic                  error_q, error_d;
    logic                  pop_vld_q, pop_vld_d;
    logic [1:0]            pop_idx_q, pop_idx_d;
    logic                  dst_push_q, dst_push_d;
    logic [DATA_WIDTH-1:0] dst_data_q, dst_data_d;
    logic                  arb_en;
    logic                  go_init;
    logic [NUM_REQ-1:0]    gnt;

    rr_arbiter u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   (~src_empty),
        .gnt   (gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RESET;
            umbral_af_q <= '0;
            umbral_ae_q <= '0;
            error_q     <= 1'b0;
            pop_vld_q   <= 1'b0;
            pop_idx_q   <= '0;
            dst_push_q  <= 1'b0;
            dst_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            umbral_af_q <= umbral_af_d;
            umbral_ae_q <= umbral_ae_d;
            error_q     <= error_d;
            pop_vld_q   <= pop_vld_d;
            pop_idx_q   <= pop_idx_d;
            dst_push_q  <= dst_push_d;
            dst_data_q  <= dst_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!cfg_init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (cfg_init)         state_d = ST_INIT;
                else if (|(~src_empty)) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (cfg_init)                     state_d = ST_INIT;
                else if (&src_empty && !pop_vld_q) state_d = ST_IDLE;
            end
        endcase
    end

    // Two-stage word pipeline: pop stage waits for the source read data, push stage drives the downstream FIFO.
    always_comb begin
        go_init     = cfg_init && (state_q == ST_IDLE || state_q == ST_ACTIVE);
        umbral_af_d = (state_q == ST_INIT) ? cfg_umbral_af : umbral_af_q;
        umbral_ae_d = (state_q == ST_INIT) ? cfg_umbral_ae : umbral_ae_q;
        error_d     = (state_q == ST_INIT) ? 1'b0 : (error_q | (|src_error));
        pop_vld_d   = (|gnt) && !go_init;
        pop_idx_d   = onehot_idx(gnt);
        dst_push_d  = pop_vld_q && !go_init;
        dst_data_d  = dst_push_d ? src_data[int'(pop_idx_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    always_comb begin
        fifo_init = !reset && (state_q == ST_IDLE || state_q == ST_ACTIVE);
        arb_en    = !reset && (state_q == ST_ACTIVE) && !dst_full && !dst_almost_full;
        src_pop   = gnt;
        dst_push  = dst_push_q && !reset;
        dst_data  = reset ? '0 : dst_data_q;
    end

    assign umbral_af_o = umbral_af_q;
    assign umbral_ae_o = umbral_ae_q;
    assign state_o     = state_q;
    assign error_o     = error_q;

endmodule
